burst_sink: RTL and testbench

BURST_SINK -- requirements
Module: burst_sink

---
 rtl/burst_sink.sv | 134 +++++++++++++
 tb/tb_burst_sink.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sink.sv
// Burst capture buffer: records an upstream write burst into a register file,
// then drains addresses 0..highest-written to a ready/valid downstream port.
module burst_sink #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          csn,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] dout,
    output logic          dvld,
    input  logic          drdy,
    output logic          busy,
    output logic [5:0]    wcnt,
    output logic          ovf
);

    localparam int            DEPTH  = 1 << AW;
    localparam logic [AW-1:0] ADDR_0 = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_1 = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] hi_q;
    logic [AW-1:0] hi_d;
    logic          any_q;
    logic          any_d;
    logic [5:0]    wcnt_q;
    logic [5:0]    wcnt_d;
    logic          ovf_q;
    logic          start_s;
    logic          wr_s;

    // Burst bookkeeping: a new burst clears the tallies before this cycle's write counts.
    always_comb begin
        start_s = (state_q == IDLE) && !csn;
        wr_s    = !csn && we && (state_q != DRAIN);
        hi_d    = start_s ? ADDR_0 : hi_q;
        any_d   = start_s ? 1'b0   : any_q;
        wcnt_d  = start_s ? 6'd0   : wcnt_q;
        if (wr_s) begin
            any_d = 1'b1;
            if (addr > hi_d) begin
                hi_d = addr;
            end else begin
                hi_d = hi_d;
            end
            if (wcnt_d != 6'd63) begin
                wcnt_d = wcnt_d + 6'd1;
            end else begin
                wcnt_d = 6'd63;
            end
        end else begin
            any_d = any_d;
        end
    end

    // Register-file storage; writes are blocked while draining.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (wr_s) begin
            mem_q[addr] <= wdata;
        end
    end

    // Control FSM with drain pointer, burst tallies and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= ADDR_0;
            hi_q     <= ADDR_0;
            any_q    <= 1'b0;
            wcnt_q   <= 6'd0;
            ovf_q    <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            any_q  <= any_d;
            wcnt_q <= wcnt_d;
            if (!csn && we && (state_q == DRAIN)) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!csn) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    if (csn) begin
                        if (any_q) begin
                            state_q  <= DRAIN;
                            rd_ptr_q <= ADDR_0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    // csn low on the final transfer is left for IDLE to see next cycle.
                    if (drdy) begin
                        if (rd_ptr_q == hi_q) begin
                            state_q <= IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + ADDR_1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dvld = (state_q == DRAIN);
    assign busy = dvld;
    assign dout = dvld ? mem_q[rd_ptr_q] : {DW{1'b0}};
    assign wcnt = wcnt_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_burst_sink.sv
// Directed bench for burst_sink: capture, drain handshake, overflow, reset abort
// and write-count saturation.
module tb_burst_sink;

    logic       clk;
    logic       rst;
    logic       csn;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] dout;
    logic       dvld;
    logic       drdy;
    logic       busy;
    logic [5:0] wcnt;
    logic       ovf;

    int         total_cnt = 0;
    int         bad_cnt   = 0;
    logic [7:0] exp_w [0:31];

    burst_sink #(.AW(5), .DW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .csn   (csn),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .dout  (dout),
        .dvld  (dvld),
        .drdy  (drdy),
        .busy  (busy),
        .wcnt  (wcnt),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        csn = 1'b1;
        we  = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        csn   = 1'b0;
        we    = 1'b1;
        addr  = 5'(a);
        wdata = 8'(d);
        step();
    endtask

    task automatic end_burst();
        csn = 1'b1;
        we  = 1'b0;
        check("capt_dvld", 32'(dvld), 32'd0);
        step();
        check("first_dvld", 32'(dvld), 32'd1);
    endtask

    task automatic drain(input int n, input bit toggle, input bit csn_last_low);
        int k   = 0;
        int cyc = 0;
        bit r   = 1'b1;
        while (k < n && cyc < 400) begin
            drdy = toggle ? r : 1'b1;
            if (csn_last_low && k == n - 1) csn = 1'b0;
            check("drain_dvld", 32'(dvld), 32'd1);
            check("drain_dout", 32'(dout), 32'(exp_w[k]));
            step();
            if (drdy) k++;
            r = ~r;
            cyc++;
        end
        check("drain_count", 32'(k), 32'(n));
        check("busy_after", 32'(busy), 32'd0);
        drdy = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        csn   = 1'b1;
        we    = 1'b0;
        addr  = 5'd0;
        wdata = 8'd0;
        drdy  = 1'b1;
        step();
        step();
        check("rst_dvld", 32'(dvld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_wcnt", 32'(wcnt), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b1;

        // 20-word burst, drained at full rate
        for (int i = 0; i < 20; i++) begin
            wr(i, 8'h40 + i);
            exp_w[i] = 8'(8'h40 + i);
        end
        check("b20_wcnt", 32'(wcnt), 32'd20);
        end_burst();
        drain(20, 1'b0, 1'b0);
        check("b20_wcnt_hold", 32'(wcnt), 32'd20);

        // same burst with drdy toggling
        for (int i = 0; i < 20; i++) wr(i, 8'h40 + i);
        end_burst();
        drain(20, 1'b1, 1'b0);

        // select without writes: no drain, wcnt cleared
        for (int i = 0; i < 5; i++) begin
            csn = 1'b0;
            we  = 1'b0;
            step();
            check("nowr_dvld", 32'(dvld), 32'd0);
        end
        csn = 1'b1;
        step();
        check("nowr_wcnt", 32'(wcnt), 32'd0);
        step();
        check("nowr_dvld_end", 32'(dvld), 32'd0);

        // sparse writes: unwritten addresses drain as zero
        do_reset();
        wr(0, 8'hAA);
        wr(7, 8'hBB);
        for (int i = 0; i < 8; i++) exp_w[i] = 8'h00;
        exp_w[0] = 8'hAA;
        exp_w[7] = 8'hBB;
        end_burst();
        drain(8, 1'b0, 1'b0);
        check("sparse_wcnt", 32'(wcnt), 32'd2);

        // write attempt during drain sets sticky ovf, data untouched
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(i, 8'h10 + i);
            exp_w[i] = 8'(8'h10 + i);
        end
        end_burst();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                csn = 1'b0; we = 1'b1; addr = 5'd2; wdata = 8'hFF;
            end else begin
                csn = 1'b1; we = 1'b0;
            end
            check("ovf_dout", 32'(dout), 32'(exp_w[k]));
            step();
        end
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_wcnt", 32'(wcnt), 32'd4);
        step();
        step();
        check("ovf_sticky", 32'(ovf), 32'd1);
        do_reset();
        check("ovf_clr", 32'(ovf), 32'd0);

        // reset during the third drained word aborts, memory cleared
        for (int i = 0; i < 6; i++) begin
            wr(i, 8'h20 + i);
            exp_w[i] = 8'(8'h20 + i);
        end
        end_burst();
        for (int k = 0; k < 2; k++) begin
            check("abort_dout", 32'(dout), 32'(exp_w[k]));
            step();
        end
        check("abort_third", 32'(dout), 32'(exp_w[2]));
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_dvld", 32'(dvld), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout0", 32'(dout), 32'd0);
        check("abort_wcnt", 32'(wcnt), 32'd0);
        wr(0, 8'h30);
        wr(3, 8'h31);
        exp_w[0] = 8'h30;
        exp_w[1] = 8'h00;
        exp_w[2] = 8'h00;
        exp_w[3] = 8'h31;
        end_burst();
        drain(4, 1'b0, 1'b1);

        // csn low on completing edge is picked up by IDLE one cycle later
        check("late_wcnt_hold", 32'(wcnt), 32'd2);
        step();
        csn = 1'b1;
        check("late_wcnt_clr", 32'(wcnt), 32'd0);
        check("late_dvld", 32'(dvld), 32'd0);
        step();
        check("late_idle", 32'(dvld), 32'd0);

        // 70 writes wrap the address space and saturate wcnt
        for (int i = 0; i < 70; i++) wr(i % 32, i);
        for (int a = 0; a < 32; a++) exp_w[a] = 8'((a < 6) ? 64 + a : 32 + a);
        check("sat_wcnt", 32'(wcnt), 32'd63);
        end_burst();
        drain(32, 1'b0, 1'b0);
        check("sat_wcnt_hold", 32'(wcnt), 32'd63);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
